catcher_strip_renderer: RTL
===========================

// Module: catcher_strip_renderer
// PURPOSE
//   Parametrised catcher/paddle renderer: on a start pulse it sweeps a horizontal strip of the
//   frame, emitting one pixel per accepted cycle to the VGA pixel writer. Paddle pixels get
//   FG_COLOR; all other pixels in the strip get BG_COLOR.
//   Adds edge clamping, a ready/valid pixel handshake and a delta mode that redraws only the
//   columns covering the old and new paddle. Sits between the position mux (mouse/keys) and the
//   VGA adapter.
// PARAMETERS
//   SCREEN_W  120     strip width in pixels (columns 0..SCREEN_W-1)
//   PADDLE_W  7       paddle width in pixels, odd, <= SCREEN_W
//   PADDLE_H  3       paddle/strip height in rows
//   Y_TOP     112     first row of the strip
//   FG_COLOR  3'b001  paddle colour
//   BG_COLOR  3'b000  erase colour
//   X_BITS    8       width of x/position
//   Y_BITS    7       width of y
// PORTS
//   clock     in   1       system clock, all state on posedge
//   reset     in   1       synchronous, active-low
//   start     in   1       request a render pass; sampled only in IDLE
//   position  in   X_BITS  paddle centre column; sampled with start
//   mode      in   1       0 = full strip, 1 = delta (old/new union); sampled with start
//   ready     in   1       pixel writer accepts the current pixel this cycle
//   plot      out  1       x/y/color hold a valid pixel
//   x         out  X_BITS  pixel column
//   y         out  Y_BITS  pixel row
//   color     out  3       pixel colour
//   busy      out  1       high from the cycle after start acceptance until done
//   done      out  1       one-cycle pulse when a pass completes
// BEHAVIOUR
//   Reset (reset==0 at a posedge): state=IDLE; plot=0, busy=0, done=0; x=0, y=0, color=0;
//     prev_valid=0. A reset during SWEEP aborts the pass immediately, with no done pulse.
//   HALF=(PADDLE_W-1)/2. left = 0 if position<HALF.
//     left = SCREEN_W-PADDLE_W if position+HALF>SCREEN_W-1. Otherwise left = position-HALF.
//     right = left+PADDLE_W-1. Compute all of this in X_BITS+1 bits so nothing wraps.
//   State machine IDLE -> SWEEP -> DONE -> IDLE.
//   IDLE: on start=1, latch new_left and mode, and compute the sweep range:
//     full mode, or delta with prev_valid=0: col_lo=0, col_hi=SCREEN_W-1.
//     delta with prev_valid=1: col_lo=min(prev_left,new_left), col_hi=max(prev_left,new_left)+PADDLE_W-1.
//     Set col=col_lo, row=0, and go to SWEEP.
//   SWEEP: plot=1, x=col, y=Y_TOP+row.
//     color=FG_COLOR if new_left<=col<=new_left+PADDLE_W-1, otherwise BG_COLOR.
//     Scan order is column-major: all PADDLE_H rows of a column, top to bottom, then col+1.
//     A pixel is transferred only when plot&&ready. While ready=0, x/y/color/plot hold unchanged.
//     On transfer of (col_hi,row PADDLE_H-1): go to DONE, plot=0, prev_left=new_left, prev_valid=1.
//   DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
//   Latency: first pixel is presented the cycle after start is accepted. With ready held high,
//     done asserts (col_hi-col_lo+1)*PADDLE_H cycles after the first pixel.
//   start in SWEEP or DONE is ignored, not queued. start and reset together: reset wins.
//   Changes on position/mode outside IDLE-with-start have no effect.
// TESTING
//   T1 full: reset, start pos=60 mode=0, ready=1 -> 360 pixels; FG exactly at x57..63 y112..114;
//     first x=0,y=112; last x=119,y=114; done one cycle later.
//   T2 clamp: pos=1 -> FG x0..6; pos=119 -> FG x113..119; pos=255 -> FG x113..119, no wrap.
//   T3 delta: after T1, start pos=65 mode=1 -> sweep x57..68 (36 pixels); BG x57..61; FG x62..68.
//   T4 stall: ready=0 for 5 cycles mid-column -> outputs frozen; pixel sequence identical to T1;
//     done delayed by 5 cycles.
//   T5 reset mid-pass: reset=0 at pixel 100 -> next cycle plot=0, busy=0, no done;
//     then delta pos=60 -> full 360-pixel sweep.
//   T6 start while busy: pulse start pos=10 during SWEEP -> ignored; exactly one done; FG at original left.

Source files
------------

// File: rtl/catcher_strip_renderer_if.sv
// Pixel request/stream bundle between the position mux, the strip renderer and the VGA writer.
// The renderer takes the slave view; whoever drives start/position/ready takes the master view.
interface catcher_strip_renderer_if #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7
);
  logic              start;
  logic [X_BITS-1:0] position;
  logic              mode;
  logic              ready;
  logic              plot;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [2:0]        color;
  logic              busy;
  logic              done;

  modport master (
    output start, position, mode, ready,
    input  plot, x, y, color, busy, done
  );

  modport slave (
    input  start, position, mode, ready,
    output plot, x, y, color, busy, done
  );
endinterface

// File: rtl/catcher_strip_renderer.sv
// Catcher/paddle strip renderer: sweeps the paddle strip column-major, one pixel per accepted
// cycle, in full mode or in delta mode (only the columns covering the old and new paddle).
module catcher_strip_renderer #(
  parameter int         SCREEN_W = 120,
  parameter int         PADDLE_W = 7,
  parameter int         PADDLE_H = 3,
  parameter int         Y_TOP    = 112,
  parameter logic [2:0] FG_COLOR = 3'b001,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter int         X_BITS   = 8,
  parameter int         Y_BITS   = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  catcher_strip_renderer_if.slave  bus
);
  localparam int HALF     = (PADDLE_W - 1) / 2;
  localparam int ROW_BITS = (PADDLE_H > 1) ? $clog2(PADDLE_H) : 1;

  // One extra bit on every column quantity so clamping and the delta span never wrap.
  localparam logic [X_BITS:0]   HALF_W   = (X_BITS+1)'(HALF);
  localparam logic [X_BITS:0]   PW_M1    = (X_BITS+1)'(PADDLE_W - 1);
  localparam logic [X_BITS:0]   MAX_COL  = (X_BITS+1)'(SCREEN_W - 1);
  localparam logic [X_BITS:0]   MAX_LEFT = (X_BITS+1)'(SCREEN_W - PADDLE_W);
  localparam logic [X_BITS:0]   COL_ONE  = (X_BITS+1)'(1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(PADDLE_H - 1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state_q, state_d;
  logic [X_BITS:0]     col_q, col_d;
  logic [X_BITS:0]     col_hi_q, col_hi_d;
  logic [X_BITS:0]     new_left_q, new_left_d;
  logic [X_BITS:0]     prev_left_q, prev_left_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                prev_valid_q, prev_valid_d;

  logic [X_BITS:0] pos_ext;
  logic [X_BITS:0] clamp_left;
  logic [X_BITS:0] lo_pick;
  logic [X_BITS:0] hi_pick;
  logic            fg_hit;

  always_comb begin
    pos_ext = {1'b0, bus.position};
    if (pos_ext < HALF_W) begin
      clamp_left = '0;
    end else if (pos_ext + HALF_W > MAX_COL) begin
      clamp_left = MAX_LEFT;
    end else begin
      clamp_left = pos_ext - HALF_W;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    col_hi_d     = col_hi_q;
    row_d        = row_q;
    new_left_d   = new_left_q;
    prev_left_d  = prev_left_q;
    prev_valid_d = prev_valid_q;
    lo_pick      = '0;
    hi_pick      = MAX_COL;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Delta without a previous paddle has nothing to erase, so it falls back to full.
          if (bus.mode && prev_valid_q) begin
            lo_pick = (prev_left_q < clamp_left) ? prev_left_q : clamp_left;
            hi_pick = ((prev_left_q > clamp_left) ? prev_left_q : clamp_left) + PW_M1;
          end
          new_left_d = clamp_left;
          col_d      = lo_pick;
          col_hi_d   = hi_pick;
          row_d      = '0;
          state_d    = SWEEP;
        end
      end
      SWEEP: begin
        if (bus.ready) begin
          if (row_q == LAST_ROW) begin
            row_d = '0;
            if (col_q == col_hi_q) begin
              state_d      = DONE;
              prev_left_d  = new_left_q;
              prev_valid_d = 1'b1;
            end else begin
              col_d = col_q + COL_ONE;
            end
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the registers, so they hold by themselves while ready is low.
  always_comb begin
    fg_hit    = (col_q >= new_left_q) && (col_q <= new_left_q + PW_M1);
    bus.plot  = (state_q == SWEEP);
    bus.busy  = (state_q == SWEEP);
    bus.done  = (state_q == DONE);
    bus.x     = '0;
    bus.y     = '0;
    bus.color = '0;
    if (state_q == SWEEP) begin
      bus.x     = col_q[X_BITS-1:0];
      bus.y     = Y_BITS'(Y_TOP) + Y_BITS'(row_q);
      bus.color = fg_hit ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      col_hi_q     <= '0;
      row_q        <= '0;
      new_left_q   <= '0;
      prev_left_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      col_hi_q     <= col_hi_d;
      row_q        <= row_d;
      new_left_q   <= new_left_d;
      prev_left_q  <= prev_left_d;
      prev_valid_q <= prev_valid_d;
    end
  end
endmodule
